// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central pipeline control for the 5-stage RV32 core. Sequences the PC,
// IF/ID and ID/EX registers:
//   - zero-latency redirect on taken jumps/branches;
//   - IF/ID forced to NOP for FLUSH_CYC cycles after a redirect;
//   - LU_CYC bubble cycles per load-use hazard;
//   - whole front end frozen while the data bus waits.
// It also keeps stall and flush performance counters.
//
// Ports
//   clk             core clock
//   rst             asynchronous, active-low reset
//   jump_flag_i     taken branch/jump resolved in EX
//   jump_addr_i     redirect target
//   load_use_i      load-use hazard detected in ID
//   mem_wait_i      data bus not ready
//   pc_jump_o       PC loads pc_jump_addr_o
//   pc_jump_addr_o  combinational copy of jump_addr_i
//   pc_hold_o       PC keeps its value
//   if_id_flush_o   IF/ID loads NOP
//   if_id_stall_o   IF/ID keeps its contents
//   id_ex_flush_o   ID/EX loads a bubble
//   id_ex_stall_o   ID/EX keeps its contents
//   state_o         0=RUN, 1=FLUSH, 2=BUBBLE
//   stall_cnt_o     cycles with pc_hold_o=1 (wraps)
//   flush_cnt_o     redirects taken (wraps)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned LU_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              load_use_i,
    input  logic              mem_wait_i,
    output logic              pc_jump_o,
    output logic [ADDR_W-1:0] pc_jump_addr_o,
    output logic              pc_hold_o,
    output logic              if_id_flush_o,
    output logic              if_id_stall_o,
    output logic              id_ex_flush_o,
    output logic              id_ex_stall_o,
    output logic [1:0]        state_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    // The redirect/load-use cycle itself counts as the first cycle, so the
    // extra state covers N-1 cycles and cnt starts at N-2.
    localparam logic       FLUSH_MULTI = (FLUSH_CYC > 32'd1);
    localparam logic       LU_MULTI    = (LU_CYC > 32'd1);
    localparam logic [3:0] FLUSH_INIT  = FLUSH_MULTI ? 4'(FLUSH_CYC - 32'd2) : 4'd0;
    localparam logic [3:0] LU_INIT     = LU_MULTI ? 4'(LU_CYC - 32'd2) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic jump_s, hold_s, if_flush_s, if_stall_s, ex_flush_s, ex_stall_s;

    // Next-state and control decode; mem_wait overrides everything and
    // freezes state so pending requests are replayed once the bus is ready.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        jump_s     = 1'b0;
        hold_s     = 1'b0;
        if_flush_s = 1'b0;
        if_stall_s = 1'b0;
        ex_flush_s = 1'b0;
        ex_stall_s = 1'b0;
        if (mem_wait_i) begin
            hold_s     = 1'b1;
            if_stall_s = 1'b1;
            ex_stall_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (jump_flag_i) begin
                        jump_s     = 1'b1;
                        if_flush_s = 1'b1;
                        ex_flush_s = 1'b1;
                        state_d    = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                        cnt_d      = FLUSH_INIT;
                    end else if (load_use_i) begin
                        hold_s     = 1'b1;
                        if_stall_s = 1'b1;
                        ex_flush_s = 1'b1;
                        state_d    = LU_MULTI ? ST_BUBBLE : ST_RUN;
                        cnt_d      = LU_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                // Requests seen here belong to squashed instructions.
                ST_FLUSH: begin
                    if_flush_s = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                // The load in EX has completed, so a jump resolved in EX is
                // genuine and must not be lost.
                ST_BUBBLE: begin
                    if (jump_flag_i) begin
                        jump_s     = 1'b1;
                        if_flush_s = 1'b1;
                        ex_flush_s = 1'b1;
                        state_d    = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                        cnt_d      = FLUSH_INIT;
                    end else begin
                        hold_s     = 1'b1;
                        if_stall_s = 1'b1;
                        ex_flush_s = 1'b1;
                        if (cnt_q == 4'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        stall_cnt_d = stall_cnt_q + {31'd0, hold_s};
        flush_cnt_d = flush_cnt_q + {31'd0, jump_s};
    end

    // State, sequencing counter and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Gating with rst forces the controls low the instant reset asserts,
    // even while requests are still present on the inputs.
    assign pc_jump_o      = rst & jump_s;
    assign pc_hold_o      = rst & hold_s;
    assign if_id_flush_o  = rst & if_flush_s;
    assign if_id_stall_o  = rst & if_stall_s;
    assign id_ex_flush_o  = rst & ex_flush_s;
    assign id_ex_stall_o  = rst & ex_stall_s;
    assign pc_jump_addr_o = jump_addr_i;
    assign state_o        = state_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two instances share the stimulus: dut_a (FLUSH_CYC=2, LU_CYC=1) and
// dut_b (FLUSH_CYC=2, LU_CYC=3). Each driven cycle pushes the expected
// control vector/state of both instances to a scoreboard queue; a monitor
// pops and compares on the falling edge. Control vector bit order is
// {pc_jump, pc_hold, if_id_flush, if_id_stall, id_ex_flush, id_ex_stall}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'd0;
    logic        load_use = 1'b0;
    logic        mem_wait = 1'b0;

    logic        pj_a, ph_a, iff_a, ifs_a, exf_a, exs_a;
    logic        pj_b, ph_b, iff_b, ifs_b, exf_b, exs_b;
    logic [31:0] addr_a, addr_b;
    logic [1:0]  st_a, st_b;
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
    logic [5:0]  ctrl_a, ctrl_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [5:0]  ca;
        logic [1:0]  sa;
        logic [5:0]  cb;
        logic [1:0]  sb;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign ctrl_a = {pj_a, ph_a, iff_a, ifs_a, exf_a, exs_a};
    assign ctrl_b = {pj_b, ph_b, iff_b, ifs_b, exf_b, exs_b};

    pipe_hazard_ctrl #(.ADDR_W(32), .FLUSH_CYC(2), .LU_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .load_use_i(load_use), .mem_wait_i(mem_wait), .pc_jump_o(pj_a),
        .pc_jump_addr_o(addr_a), .pc_hold_o(ph_a), .if_id_flush_o(iff_a),
        .if_id_stall_o(ifs_a), .id_ex_flush_o(exf_a), .id_ex_stall_o(exs_a),
        .state_o(st_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
    );

    pipe_hazard_ctrl #(.ADDR_W(32), .FLUSH_CYC(2), .LU_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .load_use_i(load_use), .mem_wait_i(mem_wait), .pc_jump_o(pj_b),
        .pc_jump_addr_o(addr_b), .pc_hold_o(ph_b), .if_id_flush_o(iff_b),
        .if_id_stall_o(ifs_b), .id_ex_flush_o(exf_b), .id_ex_stall_o(exs_b),
        .state_o(st_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
    );

    // Scoreboard monitor: compare the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            total = total + 4;
            if (ctrl_a !== mon_e.ca) begin
                bad = bad + 1;
                $display("FAIL sb_ctrl_a t=%0t: got %b want %b", $time, ctrl_a, mon_e.ca);
            end
            if (st_a !== mon_e.sa) begin
                bad = bad + 1;
                $display("FAIL sb_state_a t=%0t: got %0d want %0d", $time, st_a, mon_e.sa);
            end
            if (ctrl_b !== mon_e.cb) begin
                bad = bad + 1;
                $display("FAIL sb_ctrl_b t=%0t: got %b want %b", $time, ctrl_b, mon_e.cb);
            end
            if (st_b !== mon_e.sb) begin
                bad = bad + 1;
                $display("FAIL sb_state_b t=%0t: got %0d want %0d", $time, st_b, mon_e.sb);
            end
            total = total + 1;
            if (addr_a !== mon_e.addr || addr_b !== mon_e.addr) begin
                bad = bad + 1;
                $display("FAIL sb_addr t=%0t: got %h/%h want %h", $time, addr_a, addr_b, mon_e.addr);
            end
        end
    end

    // Drive one cycle of inputs and queue what both instances must show.
    task automatic step(input logic jf, input logic lu, input logic mw,
                        input logic [31:0] addr,
                        input logic [5:0] ca, input logic [1:0] sa,
                        input logic [5:0] cb, input logic [1:0] sb);
        exp_t e;
        jump_flag = jf;
        load_use  = lu;
        mem_wait  = mw;
        jump_addr = addr;
        e.ca = ca; e.sa = sa; e.cb = cb; e.sb = sb; e.addr = addr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        jump_flag = 1'b0;
        load_use  = 1'b0;
        mem_wait  = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total = total + 4;
        if (ctrl_a !== 6'b000000 || ctrl_b !== 6'b000000) begin
            bad = bad + 1;
            $display("FAIL reset_ctrl: got %b/%b want 000000", ctrl_a, ctrl_b);
        end
        if (st_a !== 2'd0 || st_b !== 2'd0) begin
            bad = bad + 1;
            $display("FAIL reset_state: got %0d/%0d want 0", st_a, st_b);
        end
        if (stall_a !== 32'd0 || stall_b !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL reset_stall_cnt: got %0d/%0d want 0", stall_a, stall_b);
        end
        if (flush_a !== 32'd0 || flush_b !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL reset_flush_cnt: got %0d/%0d want 0", flush_a, flush_b);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'(i), 6'b000000, 2'd0, 6'b000000, 2'd0);
        end
        total = total + 1;
        if (stall_a !== 32'd0 || flush_a !== 32'd0 || stall_b !== 32'd0 || flush_b !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL idle_counters: got %0d %0d %0d %0d want 0", stall_a, flush_a, stall_b, flush_b);
        end
    endtask

    task automatic check_counts(input string name,
                                input logic [31:0] sa, input logic [31:0] fa,
                                input logic [31:0] sb, input logic [31:0] fb);
        total = total + 2;
        if (stall_a !== sa || flush_a !== fa) begin
            bad = bad + 1;
            $display("FAIL %s_cnt_a: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, stall_a, flush_a, sa, fa);
        end
        if (stall_b !== sb || flush_b !== fb) begin
            bad = bad + 1;
            $display("FAIL %s_cnt_b: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     name, stall_b, flush_b, sb, fb);
        end
    endtask

    task automatic test_jump();
        step(1'b1, 1'b0, 1'b0, 32'h0000_0100, 6'b101010, 2'd0, 6'b101010, 2'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0104, 6'b001000, 2'd1, 6'b001000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0108, 6'b000000, 2'd0, 6'b000000, 2'd0);
        check_counts("jump", 32'd0, 32'd1, 32'd0, 32'd1);
    endtask

    task automatic test_load_use();
        step(1'b0, 1'b1, 1'b0, 32'h10, 6'b010110, 2'd0, 6'b010110, 2'd0);
        step(1'b0, 1'b0, 1'b0, 32'h14, 6'b000000, 2'd0, 6'b010110, 2'd2);
        step(1'b0, 1'b0, 1'b0, 32'h18, 6'b000000, 2'd0, 6'b010110, 2'd2);
        step(1'b0, 1'b0, 1'b0, 32'h1c, 6'b000000, 2'd0, 6'b000000, 2'd0);
        check_counts("load_use", 32'd1, 32'd0, 32'd3, 32'd0);
    endtask

    task automatic test_mem_wait();
        step(1'b1, 1'b0, 1'b0, 32'h40, 6'b101010, 2'd0, 6'b101010, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h44, 6'b010101, 2'd1, 6'b010101, 2'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h44, 6'b001000, 2'd1, 6'b001000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 32'h48, 6'b000000, 2'd0, 6'b000000, 2'd0);
        check_counts("mem_wait", 32'd4, 32'd1, 32'd4, 32'd1);
    endtask

    task automatic test_jump_vs_lu();
        step(1'b1, 1'b1, 1'b0, 32'h200, 6'b101010, 2'd0, 6'b101010, 2'd0);
        step(1'b0, 1'b0, 1'b0, 32'h204, 6'b001000, 2'd1, 6'b001000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 32'h208, 6'b000000, 2'd0, 6'b000000, 2'd0);
        check_counts("jump_vs_lu", 32'd0, 32'd1, 32'd0, 32'd1);
    endtask

    task automatic test_bubble_jump();
        step(1'b0, 1'b1, 1'b0, 32'h300, 6'b010110, 2'd0, 6'b010110, 2'd0);
        step(1'b1, 1'b0, 1'b0, 32'h304, 6'b101010, 2'd0, 6'b101010, 2'd2);
        step(1'b0, 1'b0, 1'b0, 32'h308, 6'b001000, 2'd1, 6'b001000, 2'd1);
        step(1'b0, 1'b0, 1'b0, 32'h30c, 6'b000000, 2'd0, 6'b000000, 2'd0);
        check_counts("bubble_jump", 32'd1, 32'd1, 32'd1, 32'd1);
    endtask

    task automatic test_wrap();
        force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.stall_cnt_q;
        step(1'b0, 1'b1, 1'b0, 32'h500, 6'b010110, 2'd0, 6'b010110, 2'd0);
        total = total + 1;
        if (stall_a !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL stall_wrap: got %h want 00000000", stall_a);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 32'h600, 6'b101010, 2'd0, 6'b101010, 2'd0);
        jump_flag = 1'b1;
        load_use  = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        total = total + 3;
        if (ctrl_a !== 6'b000000 || ctrl_b !== 6'b000000) begin
            bad = bad + 1;
            $display("FAIL async_reset_ctrl: got %b/%b want 000000", ctrl_a, ctrl_b);
        end
        if (st_a !== 2'd0 || st_b !== 2'd0) begin
            bad = bad + 1;
            $display("FAIL async_reset_state: got %0d/%0d want 0", st_a, st_b);
        end
        if (flush_a !== 32'd0 || flush_b !== 32'd0) begin
            bad = bad + 1;
            $display("FAIL async_reset_flush_cnt: got %0d/%0d want 0", flush_a, flush_b);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_jump();
        do_reset();
        test_load_use();
        do_reset();
        test_mem_wait();
        do_reset();
        test_jump_vs_lu();
        do_reset();
        test_bubble_jump();
        do_reset();
        test_wrap();
        do_reset();
        test_async_reset();
        @(negedge clk);
        total = total + 1;
        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_drain: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
